// File: rtl/cpld_link_pkg.sv
// Shared definitions for the CPLD serial link: FSM states, segment layout
// and the hex-to-7-segment lookup table.
package cpld_link_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_LATCH = 2'd3
  } state_t;

  // Bit positions inside the active-high segment byte {dp,g,f,e,d,c,b,a}
  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Hex digit 0..F to segment pattern, dp bit clear
  localparam logic [7:0] SEG_TABLE [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cpld_serial_link_seg7_encode.sv
// Hex nibble plus decimal point to active-high segment byte; blank wins
// over everything, including the decimal point.
module seg7_encode
  import cpld_link_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  input  logic       blank,
  output logic [7:0] seg
);

  // Table lookup, then overlay dp; blank forces the whole byte off
  always_comb begin
    seg = 8'h00;
    if (!blank) begin
      seg         = SEG_TABLE[nibble];
      seg[SEG_DP] = dp;
    end
  end

endmodule

// File: rtl/cpld_serial_link.sv
// Serial link to an I/O CPLD: each frame shifts out {digit one-hot, segment
// byte, LEDs} LSB first while shifting switch bits in, then pulses a latch
// strobe. Digits are multiplexed one per frame.
module cpld_serial_link
  import cpld_link_pkg::*;
#(
  parameter int CLK_DIV = 2048,
  parameter int N_DIG   = 2,
  parameter int LED_W   = 8,
  parameter int SW_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [4*N_DIG-1:0] seg_val,
  input  logic [N_DIG-1:0]   dp,
  input  logic [N_DIG-1:0]   blank,
  input  logic [LED_W-1:0]   led,
  output logic [SW_W-1:0]    sw,
  output logic               sw_valid,
  output logic               sw_changed,
  output logic               frame_done,
  output logic               busy,
  output logic               cpld_clk,
  output logic               cpld_ld,
  output logic               cpld_mosi,
  input  logic               cpld_miso
);

  localparam int OUT_W   = N_DIG + 8 + LED_W;
  localparam int FRAME_W = max_int(OUT_W, SW_W);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TICK_W  = $clog2(2 * FRAME_W);
  localparam int DIG_W   = (N_DIG > 1) ? $clog2(N_DIG) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [TICK_W-1:0] SHIFT_LAST = TICK_W'(2 * FRAME_W - 1);
  localparam logic [TICK_W-1:0] LATCH_LAST = TICK_W'(1);
  localparam logic [DIG_W-1:0]  DIG_LAST   = DIG_W'(N_DIG - 1);

  state_t              state_reg, state_next;
  logic [DIV_W-1:0]    div_cnt_reg;
  logic [TICK_W-1:0]   tick_cnt_reg;
  logic [DIG_W-1:0]    dig_idx_reg;
  logic                sclk_reg;
  logic                mosi_reg;
  logic [FRAME_W-1:0]  tx_reg;
  logic [FRAME_W-1:0]  rx_reg;
  logic [SW_W-1:0]     sw_reg;
  logic                sw_valid_reg;
  logic                sw_changed_reg;
  logic                frame_done_reg;
  logic                have_ref_reg;

  logic                tick;
  logic [N_DIG-1:0]    dig_onehot;
  logic [3:0]          nib_sel;
  logic                dp_sel;
  logic                blank_sel;
  logic [7:0]          seg_byte;
  logic [OUT_W-1:0]    out_word;
  logic [FRAME_W-1:0]  frame_word;

  // One-hot digit select decoded from the current digit index
  genvar gi;
  generate
    for (gi = 0; gi < N_DIG; gi++) begin : g_dig
      assign dig_onehot[gi] = (dig_idx_reg == DIG_W'(gi));
    end
  endgenerate

  // Pick the nibble, dp and blank of the digit being sent this frame
  always_comb begin
    nib_sel   = 4'h0;
    dp_sel    = 1'b0;
    blank_sel = 1'b0;
    for (int i = 0; i < N_DIG; i++) begin
      if (dig_onehot[i]) begin
        nib_sel   = seg_val[4*i +: 4];
        dp_sel    = dp[i];
        blank_sel = blank[i];
      end
    end
  end

  seg7_encode u_seg7 (
    .nibble (nib_sel),
    .dp     (dp_sel),
    .blank  (blank_sel),
    .seg    (seg_byte)
  );

  assign out_word   = {dig_onehot, seg_byte, led};
  assign frame_word = FRAME_W'(out_word);
  assign tick       = (div_cnt_reg == DIV_LAST);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic plus state-decoded outputs
  always_comb begin
    state_next = state_reg;
    busy       = (state_reg != ST_IDLE);
    cpld_ld    = (state_reg == ST_LATCH);
    case (state_reg)
      ST_IDLE:  if (en) state_next = ST_LOAD;
      ST_LOAD:  state_next = ST_SHIFT;
      ST_SHIFT: if (tick && tick_cnt_reg == SHIFT_LAST) state_next = ST_LATCH;
      ST_LATCH: if (tick && tick_cnt_reg == LATCH_LAST) state_next = en ? ST_LOAD : ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Divider, tick counter, shift registers, digit index and result pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_reg    <= '0;
      tick_cnt_reg   <= '0;
      dig_idx_reg    <= '0;
      sclk_reg       <= 1'b0;
      mosi_reg       <= 1'b0;
      tx_reg         <= '0;
      rx_reg         <= '0;
      sw_reg         <= '0;
      sw_valid_reg   <= 1'b0;
      sw_changed_reg <= 1'b0;
      frame_done_reg <= 1'b0;
      have_ref_reg   <= 1'b0;
    end else begin
      sw_valid_reg   <= 1'b0;
      sw_changed_reg <= 1'b0;
      frame_done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          div_cnt_reg  <= '0;
          tick_cnt_reg <= '0;
          sclk_reg     <= 1'b0;
          mosi_reg     <= 1'b0;
        end
        ST_LOAD: begin
          // Snapshot the inputs: bit0 goes out now, the rest wait in tx_reg
          div_cnt_reg  <= '0;
          tick_cnt_reg <= '0;
          sclk_reg     <= 1'b0;
          mosi_reg     <= frame_word[0];
          tx_reg       <= frame_word >> 1;
          rx_reg       <= '0;
        end
        ST_SHIFT: begin
          div_cnt_reg <= tick ? '0 : div_cnt_reg + 1'b1;
          if (tick) begin
            sclk_reg     <= ~sclk_reg;
            tick_cnt_reg <= (tick_cnt_reg == SHIFT_LAST) ? '0 : tick_cnt_reg + 1'b1;
            if (!sclk_reg) begin
              // Rising edge: first sample ends up in bit 0 after FRAME_W samples
              rx_reg <= {cpld_miso, rx_reg[FRAME_W-1:1]};
            end else begin
              // Falling edge: present the next bit (zeros once the frame is exhausted)
              mosi_reg <= tx_reg[0];
              tx_reg   <= tx_reg >> 1;
            end
          end
        end
        ST_LATCH: begin
          div_cnt_reg <= tick ? '0 : div_cnt_reg + 1'b1;
          sclk_reg    <= 1'b0;
          if (tick) begin
            tick_cnt_reg <= tick_cnt_reg + 1'b1;
            if (tick_cnt_reg == LATCH_LAST) begin
              tick_cnt_reg   <= '0;
              sw_reg         <= rx_reg[SW_W-1:0];
              sw_valid_reg   <= 1'b1;
              frame_done_reg <= 1'b1;
              // The first word after reset only establishes the reference
              sw_changed_reg <= have_ref_reg && (rx_reg[SW_W-1:0] != sw_reg);
              have_ref_reg   <= 1'b1;
              dig_idx_reg    <= (dig_idx_reg == DIG_LAST) ? '0 : dig_idx_reg + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign sw         = sw_reg;
  assign sw_valid   = sw_valid_reg;
  assign sw_changed = sw_changed_reg;
  assign frame_done = frame_done_reg;
  assign cpld_clk   = sclk_reg;
  assign cpld_mosi  = mosi_reg;

endmodule

// File: tb/tb_cpld_serial_link.sv
// Directed bench for cpld_serial_link with a scoreboard of expected frames
// and a CPLD model that captures mosi and returns queued switch words.
module tb_cpld_serial_link;

  localparam int CLK_DIV = 4;
  localparam int N_DIG   = 2;
  localparam int LED_W   = 8;
  localparam int SW_W    = 8;
  localparam int FRAME_W = 18;
  localparam int PERIOD  = 1 + (2 * FRAME_W + 2) * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] seg_val;
  logic [1:0] dp;
  logic [1:0] blank;
  logic [7:0] led;
  logic [7:0] sw;
  logic       sw_valid, sw_changed, frame_done, busy;
  logic       cpld_clk, cpld_ld, cpld_mosi;
  logic       cpld_miso = 1'b0;

  always #5 clk = ~clk;

  cpld_serial_link #(
    .CLK_DIV (CLK_DIV),
    .N_DIG   (N_DIG),
    .LED_W   (LED_W),
    .SW_W    (SW_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .seg_val    (seg_val),
    .dp         (dp),
    .blank      (blank),
    .led        (led),
    .sw         (sw),
    .sw_valid   (sw_valid),
    .sw_changed (sw_changed),
    .frame_done (frame_done),
    .busy       (busy),
    .cpld_clk   (cpld_clk),
    .cpld_ld    (cpld_ld),
    .cpld_mosi  (cpld_mosi),
    .cpld_miso  (cpld_miso)
  );

  typedef struct {
    logic [17:0] frame;
    logic [7:0]  sw;
    logic        changed;
  } exp_t;

  typedef struct {
    logic [17:0] mosi;
    int          nbits;
    logic [7:0]  sw;
    logic        valid;
    logic        changed;
    int          period;
    int          ld_cycles;
    int          ld_bad;
  } obs_t;

  exp_t       exp_q[$];
  obs_t       obs_q[$];
  logic [7:0] miso_q[$];
  int         checks   = 0;
  int         failures = 0;
  int         dig_m    = 0;

  localparam logic [7:0] SEG_HEX [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };

  function automatic logic [17:0] model_frame(input int dig, input logic [7:0] sv,
                                              input logic [1:0] d, input logic [1:0] b,
                                              input logic [7:0] l);
    logic [3:0] nib;
    logic [7:0] s;
    logic [1:0] oh;
    nib = (dig == 0) ? sv[3:0] : sv[7:4];
    s   = SEG_HEX[nib];
    if (d[dig]) s = s | 8'h80;
    if (b[dig]) s = 8'h00;
    oh  = (dig == 0) ? 2'b01 : 2'b10;
    return {oh, s, l};
  endfunction

  // CPLD model: capture mosi on each cpld_clk rise, drive miso for the next rise
  int          cyc = 0;
  int          start_cyc = 0;
  int          cap_idx = 0;
  int          miso_idx = 0;
  int          ld_cnt = 0;
  int          ld_bad = 0;
  logic        busy_prev = 1'b0;
  logic        sclk_prev = 1'b0;
  logic [17:0] cap = '0;
  logic [17:0] miso_word = '0;
  obs_t        mon_o;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      cap_idx   = 0;
      miso_idx  = 0;
      ld_cnt    = 0;
      ld_bad    = 0;
      cap       = '0;
      busy_prev = 1'b0;
      sclk_prev = 1'b0;
      cpld_miso = 1'b0;
    end else begin
      if (cpld_clk && !sclk_prev) begin
        if (cap_idx < FRAME_W) cap[cap_idx] = cpld_mosi;
        cap_idx++;
        miso_idx++;
      end
      if (cpld_ld) begin
        ld_cnt++;
        if (cpld_clk) ld_bad++;
      end
      if (frame_done) begin
        mon_o.mosi      = cap;
        mon_o.nbits     = cap_idx;
        mon_o.sw        = sw;
        mon_o.valid     = sw_valid;
        mon_o.changed   = sw_changed;
        mon_o.period    = cyc - start_cyc;
        mon_o.ld_cycles = ld_cnt;
        mon_o.ld_bad    = ld_bad;
        obs_q.push_back(mon_o);
        cap_idx  = 0;
        miso_idx = 0;
        ld_cnt   = 0;
        ld_bad   = 0;
        cap      = '0;
      end
      if (busy && (!busy_prev || frame_done)) begin
        start_cyc = cyc;
        miso_word = (miso_q.size() > 0) ? 18'(miso_q.pop_front()) : 18'h0;
        cap_idx   = 0;
        miso_idx  = 0;
      end
      cpld_miso = (miso_idx < FRAME_W) ? miso_word[miso_idx] : 1'b0;
      busy_prev = busy;
      sclk_prev = cpld_clk;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Queue the expected result of the next frame, built from the current inputs
  task automatic push_exp(input logic [7:0] miso_w, input logic chg);
    exp_t e;
    e.frame   = model_frame(dig_m, seg_val, dp, blank, led);
    e.sw      = miso_w;
    e.changed = chg;
    exp_q.push_back(e);
    miso_q.push_back(miso_w);
    dig_m = (dig_m + 1) % N_DIG;
  endtask

  task automatic check_frame(input string name);
    obs_t o;
    exp_t e;
    int   n;
    n = 0;
    while (obs_q.size() == 0 && n < 2 * PERIOD + 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({name, "_arrived"}, obs_q.size(), 1);
    chk({name, "_expected"}, exp_q.size() > 0, 1);
    if (obs_q.size() == 0 || exp_q.size() == 0) return;
    o = obs_q.pop_front();
    e = exp_q.pop_front();
    $display("frame %s mosi=%05h (exp %05h) sw=%02h valid=%0d changed=%0d period=%0d ld=%0d",
             name, o.mosi, e.frame, o.sw, o.valid, o.changed, o.period, o.ld_cycles);
    chk({name, "_mosi"},    o.mosi, e.frame);
    chk({name, "_nbits"},   o.nbits, FRAME_W);
    chk({name, "_sw"},      o.sw, e.sw);
    chk({name, "_valid"},   o.valid, 1);
    chk({name, "_changed"}, o.changed, e.changed);
    chk({name, "_period"},  o.period, PERIOD);
    chk({name, "_ld_len"},  o.ld_cycles, 2 * CLK_DIV);
    chk({name, "_ld_clk"},  o.ld_bad, 0);
  endtask

  task automatic check_quiet(input string name);
    chk({name, "_busy"},       busy, 0);
    chk({name, "_cpld_clk"},   cpld_clk, 0);
    chk({name, "_cpld_ld"},    cpld_ld, 0);
    chk({name, "_cpld_mosi"},  cpld_mosi, 0);
    chk({name, "_sw_valid"},   sw_valid, 0);
    chk({name, "_sw_changed"}, sw_changed, 0);
    chk({name, "_frame_done"}, frame_done, 0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; seg_val = 8'h00; dp = 2'b00; blank = 2'b00; led = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_quiet("reset");
    chk("reset_sw", sw, 8'h00);

    // Three back-to-back frames: digit 0, digit 1, then wrap to digit 0
    seg_val = 8'h31; led = 8'hA5;
    push_exp(8'h00, 1'b0);
    push_exp(8'h3C, 1'b1);
    push_exp(8'h3C, 1'b0);
    en = 1'b1;
    check_frame("f0");
    check_frame("f1");
    en = 1'b0;                          // dropped while frame 2 is in flight
    check_frame("f2");
    check_quiet("after_en_drop");
    repeat (PERIOD + 10) @(posedge clk);
    #1;
    chk("no_extra_frame", obs_q.size(), 0);

    // Blank and decimal point handling; inputs changed mid-frame apply to later frames
    seg_val = 8'h88; dp = 2'b11; blank = 2'b01; led = 8'h5A;
    push_exp(8'h3C, 1'b0);              // digit 1: 8 with dp -> FF
    push_exp(8'hC3, 1'b1);              // digit 0: blanked -> 00 despite dp
    en = 1'b1;
    check_frame("f3");
    blank = 2'b00; led = 8'h81;
    push_exp(8'hC3, 1'b0);
    push_exp(8'h00, 1'b1);              // digit 0: 8 with dp -> FF
    check_frame("f4");
    check_frame("f5");
    en = 1'b0;
    check_frame("f6");
    check_quiet("after_f6");

    // Reset in the middle of SHIFT discards the partial word
    miso_q.push_back(8'hFF);
    en = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("mid_shift_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; en = 1'b0;
    miso_q.delete();
    check_quiet("mid_reset");
    chk("mid_reset_sw", sw, 8'h00);
    dig_m = 0;
    repeat (PERIOD) @(posedge clk);
    #1;
    chk("no_frame_after_abort", obs_q.size(), 0);

    // First frame after reset: digit 0 and no sw_changed even though sw differs
    seg_val = 8'h31; dp = 2'b00; blank = 2'b00; led = 8'h0F;
    push_exp(8'h5A, 1'b0);
    en = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    check_frame("f7");
    check_quiet("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
